// File: rtl/ks_sum_capture.sv
// Registered capture stage behind the Kogge-Stone sum stage: 2-entry skid buffer with valid/ready on both sides.
// Optional KS_CAPTURE_FLAGS_EN adds per-result zero_o / ovf_o flags that travel with each entry.
module ks_sum_capture #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] sum_i,
   input  logic             cout_i,
   input  logic             a_msb_i,
   input  logic             b_msb_i,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
`ifdef KS_CAPTURE_FLAGS_EN
   output logic             zero_o,
   output logic             ovf_o,
`endif
   output logic [CNT_W-1:0] res_cnt_o
);

`ifdef KS_CAPTURE_FLAGS_EN
   localparam int ENT_W = WIDTH + 3;
`else
   localparam int ENT_W = WIDTH + 1;
`endif

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_r;
   logic [ENT_W-1:0]  main_r;
   logic [ENT_W-1:0]  skid_r;
   logic [ENT_W-1:0]  in_ent_s;
   logic              s_ready_r;
   logic              m_valid_r;
   logic [CNT_W-1:0]  res_cnt_r;
   logic              in_xfer_s;
   logic              out_xfer_s;

`ifdef KS_CAPTURE_FLAGS_EN
   // Entry layout {ovf, zero, cout, sum}; flags are derived from the raw sum-stage inputs.
   function automatic logic [ENT_W-1:0] pack_entry(
      input logic [WIDTH-1:0] sum,
      input logic             cout,
      input logic             a_msb,
      input logic             b_msb
   );
      logic zero_v;
      logic ovf_v;
      zero_v = (sum == {WIDTH{1'b0}});
      ovf_v  = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      return {ovf_v, zero_v, cout, sum};
   endfunction

   assign in_ent_s = pack_entry(sum_i, cout_i, a_msb_i, b_msb_i);
   assign zero_o   = main_r[WIDTH+1];
   assign ovf_o    = main_r[WIDTH+2];
`else
   // Operand MSBs only feed the optional overflow flag.
   function automatic logic [ENT_W-1:0] pack_entry(
      input logic [WIDTH-1:0] sum,
      input logic             cout
   );
      return {cout, sum};
   endfunction

   logic unused_msb_s;
   assign unused_msb_s = a_msb_i ^ b_msb_i;
   assign in_ent_s     = pack_entry(sum_i, cout_i);
`endif

   assign in_xfer_s  = s_valid && s_ready_r;
   assign out_xfer_s = m_valid_r && m_ready;

   assign s_ready    = s_ready_r;
   assign m_valid    = m_valid_r;
   assign sum_o      = main_r[WIDTH-1:0];
   assign cout_o     = main_r[WIDTH];
   assign res_cnt_o  = res_cnt_r;

   // Occupancy FSM with the main/skid storage, registered handshakes and delivered-result counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_EMPTY;
         main_r    <= {ENT_W{1'b0}};
         skid_r    <= {ENT_W{1'b0}};
         s_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
         res_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (out_xfer_s) begin
            res_cnt_r <= res_cnt_r + CNT_W'(1'b1);
         end else begin
            res_cnt_r <= res_cnt_r;
         end

         case (state_r)
            ST_EMPTY: begin
               s_ready_r <= 1'b1;
               if (in_xfer_s) begin
                  main_r    <= in_ent_s;
                  m_valid_r <= 1'b1;
                  state_r   <= ST_ONE;
               end else begin
                  m_valid_r <= 1'b0;
                  state_r   <= ST_EMPTY;
               end
            end
            ST_ONE: begin
               case ({in_xfer_s, out_xfer_s})
                  2'b10: begin
                     skid_r    <= in_ent_s;
                     s_ready_r <= 1'b0;
                     m_valid_r <= 1'b1;
                     state_r   <= ST_FULL;
                  end
                  // Deliver and replace in the same edge keeps full throughput.
                  2'b11: begin
                     main_r    <= in_ent_s;
                     s_ready_r <= 1'b1;
                     m_valid_r <= 1'b1;
                     state_r   <= ST_ONE;
                  end
                  2'b01: begin
                     s_ready_r <= 1'b1;
                     m_valid_r <= 1'b0;
                     state_r   <= ST_EMPTY;
                  end
                  default: begin
                     s_ready_r <= 1'b1;
                     m_valid_r <= 1'b1;
                     state_r   <= ST_ONE;
                  end
               endcase
            end
            ST_FULL: begin
               m_valid_r <= 1'b1;
               if (out_xfer_s) begin
                  main_r    <= skid_r;
                  s_ready_r <= 1'b1;
                  state_r   <= ST_ONE;
               end else begin
                  s_ready_r <= 1'b0;
                  state_r   <= ST_FULL;
               end
            end
            default: begin
               s_ready_r <= 1'b1;
               m_valid_r <= 1'b0;
               state_r   <= ST_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ks_sum_capture.sv
// Self-checking bench for ks_sum_capture: directed scenarios plus a queue scoreboard fed on accept and drained on delivery.
// Define KS_CAPTURE_FLAGS_EN to also exercise zero_o / ovf_o.
module tb_ks_sum_capture;
   localparam int WIDTH = 16;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] sum_i;
   logic             cout_i;
   logic             a_msb_i;
   logic             b_msb_i;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] sum_o;
   logic             cout_o;
   logic [CNT_W-1:0] res_cnt_o;
`ifdef KS_CAPTURE_FLAGS_EN
   logic             zero_o;
   logic             ovf_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;
   logic [WIDTH+2:0] sb_q[$];

   ks_sum_capture #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .sum_i     (sum_i),
      .cout_i    (cout_i),
      .a_msb_i   (a_msb_i),
      .b_msb_i   (b_msb_i),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .sum_o     (sum_o),
      .cout_o    (cout_o),
`ifdef KS_CAPTURE_FLAGS_EN
      .zero_o    (zero_o),
      .ovf_o     (ovf_o),
`endif
      .res_cnt_o (res_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: pop/compare on delivery, push model entry on accept (pop first so replace-in-ONE works).
   always @(negedge clk) begin
      logic [WIDTH+2:0] exp_e;
      logic             z_m;
      logic             o_m;
      if (rst_n) begin
         if (m_valid && m_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: delivered sum=%h with nothing outstanding", sum_o);
            end else begin
               exp_e = sb_q.pop_front();
               if ({cout_o, sum_o} !== exp_e[WIDTH:0]) begin
                  n_fail++;
                  $display("FAIL sb_data: got cout/sum=%b/%h expected %b/%h", cout_o, sum_o, exp_e[WIDTH], exp_e[WIDTH-1:0]);
               end
`ifdef KS_CAPTURE_FLAGS_EN
               if ({ovf_o, zero_o} !== exp_e[WIDTH+2:WIDTH+1]) begin
                  n_fail++;
                  $display("FAIL sb_flags: got ovf/zero=%b%b expected %b%b", ovf_o, zero_o, exp_e[WIDTH+2], exp_e[WIDTH+1]);
               end
`endif
            end
            exp_cnt++;
         end
         if (s_valid && s_ready) begin
            z_m = (sum_i == 16'h0000);
            o_m = (a_msb_i == b_msb_i) && (sum_i[WIDTH-1] != a_msb_i);
            sb_q.push_back({o_m, z_m, cout_i, sum_i});
         end
      end
   end

   // Global watchdog so the run can never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c);
      s_valid = v;
      sum_i   = d;
      cout_i  = c;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      sum_i = 16'h0000; cout_i = 1'b0; a_msb_i = 1'b0; b_msb_i = 1'b0;
      #2;
      n_checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_hs: m_valid=%b s_ready=%b expected 0 0", m_valid, s_ready);
      end
      n_checks++;
      if (sum_o !== 16'h0000 || cout_o !== 1'b0 || res_cnt_o !== 16'h0000) begin
         n_fail++; $display("FAIL reset_data: sum=%h cout=%b cnt=%0d expected 0", sum_o, cout_o, res_cnt_o);
      end
      #10 rst_n = 1'b1;
      tick();
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
      end
   endtask

   task automatic test_single();
      m_ready = 1'b1;
      drive(1'b1, 16'h1234, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (m_valid !== 1'b1 || sum_o !== 16'h1234 || cout_o !== 1'b1) begin
         n_fail++; $display("FAIL single_out: m_valid=%b sum=%h cout=%b expected 1 1234 1", m_valid, sum_o, cout_o);
      end
      n_checks++;
      if (res_cnt_o !== 16'd0) begin
         n_fail++; $display("FAIL single_cnt_before: cnt=%0d expected 0", res_cnt_o);
      end
      tick();
      n_checks++;
      if (res_cnt_o !== 16'd1 || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL single_cnt_after: cnt=%0d m_valid=%b expected 1 0", res_cnt_o, m_valid);
      end
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      drive(1'b1, 16'h0001, 1'b0);
      tick();
      n_checks++;
      if (s_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_ready_first: s_ready=%b expected 1", s_ready);
      end
      drive(1'b1, 16'h0002, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (s_ready !== 1'b0 || sum_o !== 16'h0001) begin
         n_fail++; $display("FAIL bp_full: s_ready=%b sum=%h expected 0 0001", s_ready, sum_o);
      end
      tick(); tick();
      n_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold: s_ready=%b m_valid=%b expected 0 1", s_ready, m_valid);
      end
      m_ready = 1'b1;
      tick();
      n_checks++;
      if (s_ready !== 1'b1 || sum_o !== 16'h0002) begin
         n_fail++; $display("FAIL bp_drain: s_ready=%b sum=%h expected 1 0002", s_ready, sum_o);
      end
      tick();
      n_checks++;
      if (m_valid !== 1'b0 || res_cnt_o !== 16'd3) begin
         n_fail++; $display("FAIL bp_done: m_valid=%b cnt=%0d expected 0 3", m_valid, res_cnt_o);
      end
   endtask

   task automatic test_streaming();
      int bubbles;
      int start;
      bubbles = 0;
      start = exp_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 16'(i), 1'(i & 1));
         tick();
         if (m_valid !== 1'b1 || s_ready !== 1'b1) bubbles++;
      end
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (bubbles != 0) begin
         n_fail++; $display("FAIL stream_bubbles: %0d stalled cycles expected 0", bubbles);
      end
      tick();
      n_checks++;
      if (res_cnt_o !== 16'(start + 100) || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL stream_count: cnt=%0d m_valid=%b expected %0d 0", res_cnt_o, m_valid, start + 100);
      end
   endtask

   task automatic test_random();
      int cycles;
      int sent;
      int start;
      logic acc;
      cycles = 0; sent = 0; acc = 1'b0;
      start = exp_cnt;
      s_valid = 1'b0;
      while ((sent < 1000 || sb_q.size() != 0 || m_valid) && cycles < 20000) begin
         if (!s_valid || acc) begin
            if (sent < 1000 && $urandom_range(0, 2) != 0) begin
               s_valid = 1'b1;
               sum_i   = 16'($urandom);
               cout_i  = 1'($urandom_range(0, 1));
               a_msb_i = 1'($urandom_range(0, 1));
               b_msb_i = 1'($urandom_range(0, 1));
            end else begin
               s_valid = 1'b0;
            end
         end
         m_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = s_valid && s_ready;
         if (acc) sent++;
         tick();
         cycles++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      n_checks++;
      if (cycles >= 20000) begin
         n_fail++; $display("FAIL rand_timeout: sent=%0d outstanding=%0d", sent, sb_q.size());
      end
      n_checks++;
      if (exp_cnt - start != 1000 || res_cnt_o !== 16'(exp_cnt)) begin
         n_fail++; $display("FAIL rand_count: delivered=%0d cnt=%0d expected 1000 %0d", exp_cnt - start, res_cnt_o, exp_cnt);
      end
   endtask

   task automatic test_mid_reset();
      m_ready = 1'b0;
      a_msb_i = 1'b0; b_msb_i = 1'b0;
      drive(1'b1, 16'hAAAA, 1'b1);
      tick();
      drive(1'b1, 16'hBBBB, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
         n_fail++; $display("FAIL mr_full: s_ready=%b m_valid=%b expected 0 1", s_ready, m_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || res_cnt_o !== 16'd0 || s_ready !== 1'b0) begin
         n_fail++; $display("FAIL mr_async: m_valid=%b cnt=%0d s_ready=%b expected 0 0 0", m_valid, res_cnt_o, s_ready);
      end
      #2 rst_n = 1'b1;
      sb_q.delete();
      exp_cnt = 0;
      m_ready = 1'b1;
      tick();
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         n_fail++; $display("FAIL mr_release: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
      end
      tick(); tick();
      n_checks++;
      if (m_valid !== 1'b0 || sum_o !== 16'h0000) begin
         n_fail++; $display("FAIL mr_stale: m_valid=%b sum=%h expected 0 0000", m_valid, sum_o);
      end
      drive(1'b1, 16'h5555, 1'b0);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      tick();
      n_checks++;
      if (res_cnt_o !== 16'd1) begin
         n_fail++; $display("FAIL mr_after: cnt=%0d expected 1", res_cnt_o);
      end
   endtask

`ifdef KS_CAPTURE_FLAGS_EN
   task automatic test_flags();
      m_ready = 1'b1;
      a_msb_i = 1'b0; b_msb_i = 1'b0;
      drive(1'b1, 16'h8000, 1'b0);
      tick();
      n_checks++;
      if (ovf_o !== 1'b1 || zero_o !== 1'b0) begin
         n_fail++; $display("FAIL flags_ovf: ovf=%b zero=%b expected 1 0", ovf_o, zero_o);
      end
      drive(1'b1, 16'h0000, 1'b1);
      tick();
      drive(1'b0, 16'h0000, 1'b0);
      n_checks++;
      if (zero_o !== 1'b1 || ovf_o !== 1'b0 || cout_o !== 1'b1) begin
         n_fail++; $display("FAIL flags_zero: zero=%b ovf=%b cout=%b expected 1 0 1", zero_o, ovf_o, cout_o);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_streaming();
      test_random();
`ifdef KS_CAPTURE_FLAGS_EN
      test_flags();
`endif
      test_mid_reset();
      tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d results never delivered", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
